rv32i_wb_arbiter: RTL
=====================

RV32I_WB_ARBITER -- requirements
Module: rv32i_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of write-back data.
REQ-002 Parameter: ADDR_W, default 5, width of register index.
REQ-003 Parameter: CNT_W, default 16, width of statistics counters.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port: clk, input, 1, sole clock, rising edge.
REQ-006 Port: reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-007 Port: req0_valid, input, 1, requester 0 (ALU) has a write pending.
REQ-008 Port: req0_reg, input, ADDR_W, requester 0 destination register.
REQ-009 Port: req0_data, input, DATA_W, requester 0 write data.
REQ-010 Port: req0_ready, output, 1, requester 0 transfer accepted this cycle.
REQ-011 Ports: req1_valid, req1_reg, req1_data, req1_ready, same as requester 0, for requester 1 (load unit).
REQ-012 Port: stall, input, 1, high blocks all grants.
REQ-013 Port: wb_enable, output, 1, register-file write enable.
REQ-014 Port: wb_reg, output, ADDR_W, register-file write index.
REQ-015 Port: wb_data, output, DATA_W, register-file write data.
REQ-016 Port: last_grant, output, 2, one-hot id of the most recently granted requester; 00 before first grant.
REQ-017 Port: conflict_cnt, output, CNT_W, cycles in which both requesters were valid and stall was low.
REQ-018 Port: drop_cnt, output, CNT_W, accepted transfers targeting register 0.

Function
REQ-019 Arbitration state SHALL be a 2-state priority pointer: PRI0 (requester 0 wins ties) and PRI1 (requester 1 wins ties).
REQ-020 Grant decision SHALL be combinational from same-cycle inputs: stall=1 -> no grant; exactly one valid -> grant it; both valid -> grant the requester holding priority; none valid -> no grant.
REQ-021 reqN_ready SHALL equal the grant to N, so at most one ready is high per cycle and ready is never high without the matching valid.
REQ-022 A transfer completes on a rising edge where reqN_valid and reqN_ready are both high; a requester SHALL hold valid, reg and data stable until its transfer completes.
REQ-023 After a completed transfer from N, the pointer SHALL move to give the other requester priority; without a transfer the pointer SHALL hold.
REQ-024 wb_enable, wb_reg and wb_data SHALL be registered: one cycle of latency from transfer edge to register-file write.
REQ-025 On a completed transfer with reg != 0: next cycle wb_enable=1, wb_reg/wb_data = the winner's reg/data.
REQ-026 On a completed transfer with reg == 0: the transfer is consumed, next cycle wb_enable=0, and drop_cnt increments.
REQ-027 With no completed transfer, wb_enable SHALL be 0 the next cycle while wb_reg/wb_data hold their last value.
REQ-028 Two requests to the same register SHALL be serialised in grant order, so the later-granted data is the final register value.
REQ-029 conflict_cnt and drop_cnt SHALL saturate at all-ones and never wrap.
REQ-030 last_grant SHALL update on every completed transfer, including register-0 transfers.
REQ-031 Under continuous requests from both sides with stall low, grants SHALL alternate every cycle: maximum wait is 1 cycle.

Reset
REQ-032 When reset is asserted (0), asynchronously and regardless of clk: pointer=PRI0, wb_enable=0, wb_reg=0, wb_data=0, last_grant=00, both counters=0.
REQ-033 While reset=0, both ready outputs SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL cancel any write not yet presented on wb_*; no write SHALL be issued in the first cycle after deassertion.

Verification
REQ-035 Single request: after reset, req0 valid reg=10 data=0x25 for one cycle -> req0_ready=1 that cycle; next cycle wb_enable=1, wb_reg=10, wb_data=0x25; last_grant=01.
REQ-036 Tie with rotation: both valid (req0 reg=5 data=0x20, req1 reg=6 data=0x30) held -> cycle 0 grants req0, cycle 1 grants req1; wb shows 5/0x20 then 6/0x30; conflict_cnt=1 after both complete.
REQ-037 x0 drop: req1 valid reg=0 data=321 -> req1_ready=1; next cycle wb_enable=0; drop_cnt=1; pointer moves to PRI0.
REQ-038 Stall: both valid with stall=1 for 3 cycles -> readies 0, wb_enable 0, conflict_cnt unchanged; on stall=0, PRI0 pointer grants req0 first.
REQ-039 Reset mid-stream: both valid alternating, reset pulled low between edges -> wb_enable drops to 0 immediately, counters clear; after release, first grant goes to req0.
REQ-040 Saturation: force 2^CNT_W+3 x0 transfers -> drop_cnt holds 0xFFFF (default CNT_W).

Source files
------------

// File: rtl/rv32i_wb_arbiter.sv
// Two-requester write-back arbiter for an RV32I core: ALU (req0) vs load unit (req1).
// Rotating tie priority, registered register-file write port, saturating statistics.
module rv32i_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              stall,
  output logic              wb_enable,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        last_grant,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_e;

  pri_e              ptr_q, ptr_d;
  logic              wb_enable_q, wb_enable_d;
  logic [ADDR_W-1:0] wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              gnt0, gnt1, xfer, to_x0;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Grant is purely combinational; readies are forced low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset && !stall) begin
      if (req0_valid && (!req1_valid || ptr_q == PRI0)) gnt0 = 1'b1;
      else if (req1_valid)                                gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign win_reg    = gnt1 ? req1_reg  : req0_reg;
  assign win_data   = gnt1 ? req1_data : req0_data;
  assign to_x0      = (win_reg == '0);

  always_comb begin
    ptr_d          = ptr_q;
    wb_enable_d    = 1'b0;
    wb_reg_d       = wb_reg_q;
    wb_data_d      = wb_data_q;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;
    drop_cnt_d     = drop_cnt_q;

    if (gnt0) ptr_d = PRI1;
    if (gnt1) ptr_d = PRI0;

    if (xfer) begin
      last_grant_d = {gnt1, gnt0};
      // Writes to x0 are consumed but never reach the register file.
      if (to_x0) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
      end else begin
        wb_enable_d = 1'b1;
        wb_reg_d    = win_reg;
        wb_data_d   = win_data;
      end
    end

    if (req0_valid && req1_valid && !stall) conflict_cnt_d = sat_inc(conflict_cnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q          <= PRI0;
      wb_enable_q    <= 1'b0;
      wb_reg_q       <= '0;
      wb_data_q      <= '0;
      last_grant_q   <= 2'b00;
      conflict_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      ptr_q          <= ptr_d;
      wb_enable_q    <= wb_enable_d;
      wb_reg_q       <= wb_reg_d;
      wb_data_q      <= wb_data_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign wb_enable    = wb_enable_q;
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_data_q;
  assign last_grant   = last_grant_q;
  assign conflict_cnt = conflict_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
